rtc_set_ctrl: RTL and testbench

Mode controller that sequences manual time-setting of the HH:MM:SS counter block. It consumes single-cycle debounced button pulses and a held-level for the increment button. It produces field-increment strobes, a run-enable for the 1 Hz advance, a prescaler resync pulse, and a per-digit blanking mask that blinks the field being edited. It sits between the button debouncers and the time counters/seven-segment encoders.

---
 rtl/rtc_pkg.sv | 45 ++++
 rtl/rtc_ms_timer.sv | 36 +++
 rtl/rtc_set_ctrl.sv | 151 +++++++++++++++
 tb/tb_rtc_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared types and constants for the RTC time-setting controller.
//   mode_e       : controller state, also driven out as the status LED code
//   FLD_*        : one-hot increment strobes for the counter block
//   BLANK_*      : seven-segment digit blanking bits for each field
//   field_strobe : state -> one-hot strobe of the field being edited
//   field_blank  : state -> blanking bits of the field being edited
// -----------------------------------------------------------------------------
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_e;

    localparam logic [2:0] FLD_SEC = 3'b001;
    localparam logic [2:0] FLD_MIN = 3'b010;
    localparam logic [2:0] FLD_HR  = 3'b100;

    localparam logic [5:0] BLANK_SEC = 6'b000011;
    localparam logic [5:0] BLANK_MIN = 6'b001100;
    localparam logic [5:0] BLANK_HR  = 6'b110000;

    function automatic logic [2:0] field_strobe(input mode_e m);
        case (m)
            SET_HR:  return FLD_HR;
            SET_MIN: return FLD_MIN;
            SET_SEC: return FLD_SEC;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [5:0] field_blank(input mode_e m);
        case (m)
            SET_HR:  return BLANK_HR;
            SET_MIN: return BLANK_MIN;
            SET_SEC: return BLANK_SEC;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/rtc_ms_timer.sv
// -----------------------------------------------------------------------------
// rtc_ms_timer
// Loadable down-counter advanced by the 1 kHz tick enable.
//   clk, rst  : clock, asynchronous active-low reset (count cleared)
//   tick      : single-cycle ms enable
//   load      : load load_val this cycle (wins over the tick)
//   load_val  : reload value in ms
//   done      : high in the tick cycle that takes the count from 1 to 0
// The counter parks at zero, so an unreloaded timer fires only once.
// -----------------------------------------------------------------------------
module rtc_ms_timer #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign done = tick && (count_reg == CNT_W'(1));

endmodule

// File: rtl/rtc_set_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_set_ctrl
// Manual time-setting sequencer for the HH:MM:SS counter block.
//   clk, rst     : 50 MHz clock, asynchronous active-low reset
//   tick_1khz    : single-cycle 1 ms enable
//   btn_mode_p   : enter / leave set mode (pulse)
//   btn_next_p   : select next field (pulse)
//   btn_inc_p    : increment selected field (pulse)
//   btn_inc_lvl  : increment button held (level), drives auto-repeat
//   run_en       : counters advance on the 1 Hz enable
//   inc_field    : one-hot increment strobe {hr, min, sec}
//   resync       : one-cycle pulse on return to RUN, clears the 1 Hz prescaler
//   blank_mask   : digit blanking {hr10, hr1, min10, min1, sec10, sec1}
//   mode_state   : current state code for status LEDs
// Button priority within a cycle is mode > next > inc; losers are dropped.
// -----------------------------------------------------------------------------
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 150,
    parameter int BLINK_HALF_MS    = 250,
    parameter int TIMEOUT_MS       = 10000,
    parameter int CNT_W            = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1khz,
    input  logic       btn_mode_p,
    input  logic       btn_next_p,
    input  logic       btn_inc_p,
    input  logic       btn_inc_lvl,
    output logic       run_en,
    output logic [2:0] inc_field,
    output logic       resync,
    output logic [5:0] blank_mask,
    output logic [1:0] mode_state
);

    localparam int TMR_HOLD  = 0;
    localparam int TMR_IDLE  = 1;
    localparam int TMR_BLINK = 2;
    localparam int NUM_TMR   = 3;

    localparam logic [CNT_W-1:0] DELAY_LD   = CNT_W'(REPEAT_DELAY_MS);
    localparam logic [CNT_W-1:0] PERIOD_LD  = CNT_W'(REPEAT_PERIOD_MS);
    localparam logic [CNT_W-1:0] BLINK_LD   = CNT_W'(BLINK_HALF_MS);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_MS);

    mode_e      state_reg, state_next;
    logic       run_en_reg;
    logic       resync_reg;
    logic [2:0] inc_field_reg;
    logic       phase_on_reg, phase_on_next;

    logic             tmr_load [NUM_TMR];
    logic [CNT_W-1:0] tmr_val  [NUM_TMR];
    logic             tmr_done [NUM_TMR];

    logic in_set;
    logic hold_clr, repeat_fire;
    logic idle_clr, timeout;
    logic blink_clr;
    logic strobe;

    // Hold/repeat, idle timeout and blink half-period share one timer design.
    generate
        for (genvar gi = 0; gi < NUM_TMR; gi++) begin : g_tmr
            rtc_ms_timer #(
                .CNT_W (CNT_W)
            ) u_tmr (
                .clk      (clk),
                .rst      (rst),
                .tick     (tick_1khz),
                .load     (tmr_load[gi]),
                .load_val (tmr_val[gi]),
                .done     (tmr_done[gi])
            );
        end
    endgenerate

    always_comb begin
        in_set = (state_reg != RUN);

        // Repeat stops as soon as the button is released or the field/state
        // changes; the timer then sits preloaded with the initial delay.
        hold_clr    = !btn_inc_lvl || !in_set || btn_mode_p || btn_next_p;
        repeat_fire = tmr_done[TMR_HOLD] && !hold_clr;

        // Holding inc counts as activity, so an auto-repeat never times out.
        idle_clr = !in_set || btn_mode_p || btn_next_p || btn_inc_p || btn_inc_lvl;
        timeout  = tmr_done[TMR_IDLE] && !idle_clr;

        strobe = in_set && !btn_mode_p && !btn_next_p && (btn_inc_p || repeat_fire);

        state_next = state_reg;
        if (btn_mode_p) begin
            state_next = in_set ? RUN : SET_HR;
        end else if (in_set) begin
            if (btn_next_p) begin
                case (state_reg)
                    SET_HR:  state_next = SET_MIN;
                    SET_MIN: state_next = SET_SEC;
                    default: state_next = SET_HR;
                endcase
            end else if (timeout) begin
                state_next = RUN;
            end
        end

        // Keep the edited digits visible right after any change to them.
        blink_clr = !in_set || (state_next != state_reg) || strobe;

        phase_on_next = phase_on_reg;
        if (blink_clr) begin
            phase_on_next = 1'b1;
        end else if (tmr_done[TMR_BLINK]) begin
            phase_on_next = !phase_on_reg;
        end

        tmr_load[TMR_HOLD]  = hold_clr || repeat_fire;
        tmr_val[TMR_HOLD]   = hold_clr ? DELAY_LD : PERIOD_LD;
        tmr_load[TMR_IDLE]  = idle_clr;
        tmr_val[TMR_IDLE]   = TIMEOUT_LD;
        tmr_load[TMR_BLINK] = blink_clr || tmr_done[TMR_BLINK];
        tmr_val[TMR_BLINK]  = BLINK_LD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            run_en_reg    <= 1'b1;
            resync_reg    <= 1'b0;
            inc_field_reg <= 3'b000;
            phase_on_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            run_en_reg    <= (state_next == RUN);
            resync_reg    <= in_set && (state_next == RUN);
            inc_field_reg <= strobe ? field_strobe(state_reg) : 3'b000;
            phase_on_reg  <= phase_on_next;
        end
    end

    assign run_en     = run_en_reg;
    assign resync     = resync_reg;
    assign inc_field  = inc_field_reg;
    assign mode_state = state_reg;
    assign blank_mask = (state_reg != RUN && !phase_on_reg) ? field_blank(state_reg) : 6'b000000;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
module tb_rtc_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1khz;
    logic       btn_mode_p;
    logic       btn_next_p;
    logic       btn_inc_p;
    logic       btn_inc_lvl;
    logic       run_en;
    logic [2:0] inc_field;
    logic       resync;
    logic [5:0] blank_mask;
    logic [1:0] mode_state;

    int errors = 0;
    int checks = 0;
    int ph     = 0;
    logic tick_en   = 1'b0;
    logic last_tick = 1'b0;

    rtc_set_ctrl #(
        .REPEAT_DELAY_MS  (5),
        .REPEAT_PERIOD_MS (2),
        .BLINK_HALF_MS    (3),
        .TIMEOUT_MS       (20),
        .CNT_W            (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1khz   (tick_1khz),
        .btn_mode_p  (btn_mode_p),
        .btn_next_p  (btn_next_p),
        .btn_inc_p   (btn_inc_p),
        .btn_inc_lvl (btn_inc_lvl),
        .run_en      (run_en),
        .inc_field   (inc_field),
        .resync      (resync),
        .blank_mask  (blank_mask),
        .mode_state  (mode_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mode;
        logic       next;
        logic       inc;
        logic       lvl;
        logic [1:0] st;
        logic       run;
        logic [2:0] fld;
        logic       rs;
        logic [5:0] blank;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: tick every 4th cycle when enabled, pulses last one cycle,
    // outputs are observed 1 time unit after the edge.
    task automatic step();
        tick_1khz = tick_en && (ph == 3);
        ph = (ph + 1) % 4;
        @(posedge clk);
        #1;
        last_tick   = tick_1khz;
        btn_mode_p  = 1'b0;
        btn_next_p  = 1'b0;
        btn_inc_p   = 1'b0;
    endtask

    initial begin
        int n, cnt, strobes, it;
        logic done;

        rst = 1'b0;
        tick_1khz = 1'b0;
        btn_mode_p = 1'b0;
        btn_next_p = 1'b0;
        btn_inc_p = 1'b0;
        btn_inc_lvl = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", mode_state, 0);
        chk("reset_run_en", run_en, 1);
        chk("reset_inc_field", inc_field, 0);
        chk("reset_resync", resync, 0);
        chk("reset_blank", blank_mask, 0);
        rst = 1'b1;
        step();

        // Tick held low: pulses alone drive the state machine.
        //                 mode next inc lvl st  run fld     rs blank
        vq.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'd1,1'b0,3'b100,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,2'd2,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,2'd3,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,3'b001,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,2'd1,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'd0,1'b1,3'b000,1'b1,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'd0,1'b1,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,2'd0,1'b1,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,2'd2,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b1,1'b1,1'b0,2'd0,1'b1,3'b000,1'b1,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,2'd2,1'b0,3'b000,1'b0,6'd0});
        vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,3'b010,1'b0,6'd0});
        vq.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'd0,1'b1,3'b000,1'b1,6'd0});

        foreach (vq[i]) begin
            btn_mode_p  = vq[i].mode;
            btn_next_p  = vq[i].next;
            btn_inc_p   = vq[i].inc;
            btn_inc_lvl = vq[i].lvl;
            step();
            $display("vec %0d: m=%b n=%b i=%b -> state=%0d run_en=%b inc=%b resync=%b blank=%b",
                     i, vq[i].mode, vq[i].next, vq[i].inc, mode_state, run_en, inc_field, resync, blank_mask);
            chk($sformatf("vec%0d_state", i), mode_state, vq[i].st);
            chk($sformatf("vec%0d_run_en", i), run_en, vq[i].run);
            chk($sformatf("vec%0d_inc_field", i), inc_field, vq[i].fld);
            chk($sformatf("vec%0d_resync", i), resync, vq[i].rs);
            chk($sformatf("vec%0d_blank", i), blank_mask, vq[i].blank);
        end

        // Auto-repeat in SET_MIN: strobes at the pulse, then hold ticks 5,7,9,11.
        tick_en = 1'b1;
        btn_mode_p = 1'b1; step();
        btn_next_p = 1'b1; step();
        chk("rep_state", mode_state, 2);
        btn_inc_p = 1'b1;
        btn_inc_lvl = 1'b1;
        cnt = 0;
        strobes = 0;
        for (n = 0; n < 200 && cnt < 11; n++) begin
            logic pulse;
            pulse = btn_inc_p;
            step();
            if (last_tick) cnt++;
            if (pulse || (last_tick && cnt >= 5 && ((cnt - 5) % 2 == 0))) begin
                chk($sformatf("rep_strobe_t%0d", cnt), inc_field, 3'b010);
            end else begin
                chk($sformatf("rep_quiet_t%0d", cnt), inc_field, 3'b000);
            end
            if (inc_field != 3'b000) strobes++;
        end
        $display("repeat: held %0d ticks, %0d strobes", cnt, strobes);
        btn_inc_lvl = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("rep_released", inc_field, 3'b000);
            if (inc_field != 3'b000) strobes++;
        end
        chk("rep_total_strobes", strobes, 5);

        // Blink in SET_SEC: phase flips every 3 ticks, inc restarts it visible.
        btn_next_p = 1'b1; step();
        chk("blink_state", mode_state, 3);
        chk("blink_entry", blank_mask, 0);
        cnt = 0;
        for (n = 0; n < 100 && cnt < 4; n++) begin
            step();
            if (last_tick) cnt++;
            chk($sformatf("blink_t%0d", cnt), blank_mask, ((cnt / 3) % 2 == 1) ? 6'b000011 : 6'b000000);
        end
        chk("blink_off_before_inc", blank_mask, 6'b000011);
        btn_inc_p = 1'b1; step();
        chk("blink_inc_strobe", inc_field, 3'b001);
        chk("blink_inc_visible", blank_mask, 0);
        cnt = 0;
        for (n = 0; n < 100 && cnt < 7; n++) begin
            step();
            if (last_tick) cnt++;
            chk($sformatf("blink_re_t%0d", cnt), blank_mask, ((cnt / 3) % 2 == 1) ? 6'b000011 : 6'b000000);
        end

        // Timeout: 20 idle ticks return to RUN with resync.
        btn_mode_p = 1'b1; step();
        chk("to_exit_mode", resync, 1);
        btn_mode_p = 1'b1; step();
        chk("to_enter", mode_state, 1);
        it = 0;
        done = 1'b0;
        for (n = 0; n < 400 && !done; n++) begin
            step();
            if (last_tick) it++;
            if (it == 20) begin
                chk("to1_state", mode_state, 0);
                chk("to1_run_en", run_en, 1);
                chk("to1_resync", resync, 1);
                done = 1'b1;
            end else begin
                chk($sformatf("to1_wait_t%0d", it), mode_state, 1);
            end
        end
        if (!done) chk("to1_bound", 0, 1);
        $display("timeout: exit after %0d ticks", it);

        // Inc at tick 15 postpones the exit to tick 35.
        step();
        chk("to2_resync_single", resync, 0);
        btn_mode_p = 1'b1; step();
        it = 0;
        for (n = 0; n < 400 && it < 15; n++) begin
            step();
            if (last_tick) it++;
        end
        btn_inc_p = 1'b1; step();
        chk("to2_inc_strobe", inc_field, 3'b100);
        done = 1'b0;
        for (n = 0; n < 400 && !done; n++) begin
            step();
            if (last_tick) it++;
            if (it == 35) begin
                chk("to2_state", mode_state, 0);
                chk("to2_resync", resync, 1);
                done = 1'b1;
            end else begin
                chk($sformatf("to2_wait_t%0d", it), mode_state, 1);
            end
        end
        if (!done) chk("to2_bound", 0, 1);
        $display("timeout with inc: exit after %0d ticks", it);

        // Asynchronous reset while a field is blanked in SET_SEC.
        btn_mode_p = 1'b1; step();
        btn_next_p = 1'b1; step();
        btn_next_p = 1'b1; step();
        chk("rst_pre_state", mode_state, 3);
        cnt = 0;
        for (n = 0; n < 100 && cnt < 3; n++) begin
            step();
            if (last_tick) cnt++;
        end
        chk("rst_pre_blank", blank_mask, 6'b000011);
        rst = 1'b0;
        #2;
        chk("rst_async_state", mode_state, 0);
        chk("rst_async_run_en", run_en, 1);
        chk("rst_async_blank", blank_mask, 0);
        chk("rst_async_resync", resync, 0);
        chk("rst_async_inc", inc_field, 0);
        step();
        step();
        chk("rst_hold_resync", resync, 0);
        rst = 1'b1;
        step();
        chk("rst_after_state", mode_state, 0);
        chk("rst_after_run_en", run_en, 1);
        chk("rst_after_resync", resync, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
